// File: rtl/tour_cmd_seq.sv
// Replays a solved knight's tour as vertical/horizontal command pairs to cmd_proc, muxed with UART commands; `TOUR_CMD_SEQ_STEP_EN adds single-step PAUSE.
// Commands are presented combinationally from the current state and move; each leg waits for clr_cmd_rdy and send_resp handshakes.
module tour_cmd_seq #(
  parameter int         NUM_MOVES  = 24,
  parameter int         IDX_W      = 5,
  parameter logic [3:0] MOVE_OP    = 4'h2,
  parameter logic [3:0] FANFARE_OP = 4'h3,
  parameter logic [3:0] ABORT_OP   = 4'hF,
  parameter logic [7:0] HDG_N      = 8'h00,
  parameter logic [7:0] HDG_W      = 8'h3F,
  parameter logic [7:0] HDG_S      = 8'h7F,
  parameter logic [7:0] HDG_E      = 8'hBF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
`ifdef TOUR_CMD_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             tour_err
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOVES - 1);
  localparam logic [7:0]       RESP_IDLE = 8'hA5;
  localparam logic [7:0]       RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VERT,
    S_WAIT_V,
    S_HORZ,
    S_WAIT_H
`ifdef TOUR_CMD_SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;

`ifdef TOUR_CMD_SEQ_STEP_EN
  localparam state_t S_ENTRY = S_PAUSE;
`else
  localparam state_t S_ENTRY = S_VERT;
`endif

  state_t           r_state;
  logic [IDX_W-1:0] r_mv_indx;
  logic             r_tour_done;
  logic             r_tour_err;
  logic             r_abort_req;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_abort_nxt;

  logic [3:0]       w_dx_mag;
  logic [3:0]       w_dy_mag;
  logic             w_dx_pos;
  logic             w_dy_pos;
  logic             w_legal;
  logic             w_abort_in;
  logic             w_busy;
  logic             w_last;
  logic [15:0]      w_vert_cmd;
  logic [15:0]      w_horz_cmd;

  // Knight move table: one-hot bit -> (dx, dy) as sign + magnitude
  always_comb begin
    w_dx_mag = 4'd0;
    w_dy_mag = 4'd0;
    w_dx_pos = 1'b0;
    w_dy_pos = 1'b0;
    case (move)
      8'h01: begin w_dx_mag = 4'd1; w_dx_pos = 1'b1; w_dy_mag = 4'd2; w_dy_pos = 1'b1; end
      8'h02: begin w_dx_mag = 4'd1; w_dx_pos = 1'b0; w_dy_mag = 4'd2; w_dy_pos = 1'b1; end
      8'h04: begin w_dx_mag = 4'd2; w_dx_pos = 1'b0; w_dy_mag = 4'd1; w_dy_pos = 1'b1; end
      8'h08: begin w_dx_mag = 4'd2; w_dx_pos = 1'b0; w_dy_mag = 4'd1; w_dy_pos = 1'b0; end
      8'h10: begin w_dx_mag = 4'd1; w_dx_pos = 1'b0; w_dy_mag = 4'd2; w_dy_pos = 1'b0; end
      8'h20: begin w_dx_mag = 4'd1; w_dx_pos = 1'b1; w_dy_mag = 4'd2; w_dy_pos = 1'b0; end
      8'h40: begin w_dx_mag = 4'd2; w_dx_pos = 1'b1; w_dy_mag = 4'd1; w_dy_pos = 1'b0; end
      8'h80: begin w_dx_mag = 4'd2; w_dx_pos = 1'b1; w_dy_mag = 4'd1; w_dy_pos = 1'b1; end
      default: begin
        w_dx_mag = 4'd0;
        w_dy_mag = 4'd0;
      end
    endcase
  end

  assign w_legal    = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign w_vert_cmd = {MOVE_OP, (w_dy_pos ? HDG_N : HDG_S), w_dy_mag};
  assign w_horz_cmd = {FANFARE_OP, (w_dx_pos ? HDG_E : HDG_W), w_dx_mag};
  assign w_abort_in = cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OP);
  assign w_busy     = (r_state != S_IDLE);
  assign w_last     = (r_mv_indx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_mv_indx;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_tour_err;
    w_abort_nxt = r_abort_req;
    case (r_state)
      S_IDLE: begin
        if (start_tour) begin
          w_idx_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_abort_nxt = 1'b0;
          w_state_nxt = S_ENTRY;
        end
      end
      S_VERT: begin
        if (!w_legal) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (clr_cmd_rdy) begin
          w_state_nxt = S_WAIT_V;
        end
      end
      S_WAIT_V: begin
        if (send_resp) begin
          w_state_nxt = r_abort_req ? S_IDLE : S_HORZ;
        end
      end
      S_HORZ: begin
        if (clr_cmd_rdy) begin
          w_state_nxt = S_WAIT_H;
        end
      end
      S_WAIT_H: begin
        if (send_resp) begin
          if (r_abort_req) begin
            w_state_nxt = S_IDLE;
          end else if (w_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_mv_indx + 1'b1;
            w_state_nxt = S_ENTRY;
          end
        end
      end
`ifdef TOUR_CMD_SEQ_STEP_EN
      S_PAUSE: begin
        if (w_abort_in || r_abort_req) begin
          w_state_nxt = S_IDLE;
        end else if (step) begin
          w_state_nxt = S_VERT;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // UART abort is only meaningful mid-tour; the in-flight leg still completes
    if (w_busy && w_abort_in) begin
      w_abort_nxt = 1'b1;
      w_err_nxt   = 1'b1;
    end
  end

  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = 1'b0;
    resp    = RESP_BUSY;
    case (r_state)
      S_IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_IDLE;
      end
      S_VERT: begin
        cmd     = w_vert_cmd;
        cmd_rdy = w_legal;
      end
      S_WAIT_V: begin
        cmd  = w_vert_cmd;
        resp = r_abort_req ? RESP_IDLE : RESP_BUSY;
      end
      S_HORZ: begin
        cmd     = w_horz_cmd;
        cmd_rdy = 1'b1;
      end
      S_WAIT_H: begin
        cmd  = w_horz_cmd;
        resp = (w_last || r_abort_req) ? RESP_IDLE : RESP_BUSY;
      end
      default: begin
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mv_indx   <= '0;
      r_tour_done <= 1'b0;
      r_tour_err  <= 1'b0;
      r_abort_req <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mv_indx   <= w_idx_nxt;
      r_tour_done <= w_done_nxt;
      r_tour_err  <= w_err_nxt;
      r_abort_req <= w_abort_nxt;
    end
  end

  assign mv_indx   = r_mv_indx;
  assign tour_busy = w_busy;
  assign tour_done = r_tour_done;
  assign tour_err  = r_tour_err;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: move-table vectors replayed through full tours plus abort, illegal-move and reset sequences.
module tb_tour_cmd_seq;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_tour;
  logic [7:0]    move;
  logic [IW-1:0] mv_indx;
  logic [15:0]   cmd_UART;
  logic          cmd_rdy_UART;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy;
  logic          send_resp;
  logic [7:0]    resp;
  logic          tour_busy;
  logic          tour_done;
  logic          tour_err;

  logic [7:0]    tour_mem [0:31];

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } vec_t;
  vec_t vecs [8];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int leg_cnt = 0;

  tour_cmd_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp),
    .tour_busy    (tour_busy),
    .tour_done    (tour_done),
    .tour_err     (tour_err)
  );

  assign move = tour_mem[mv_indx];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tour_done === 1'b1) done_cnt++;
    if (cmd_rdy === 1'b1 && clr_cmd_rdy === 1'b1 && tour_busy === 1'b1) leg_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk(nm, 16'(cmd_rdy), 16'd1);
  endtask

  task automatic run_move(input int i, input logic [7:0] exp_resp_h);
    vec_t e;
    e = vecs[i % 8];
    chk("mv_indx", 16'(mv_indx), 16'(i));
    wait_rdy("vert_rdy");
    chk("vert_cmd", cmd, e.v);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("wait_v_rdy", 16'(cmd_rdy), 16'd0);
    chk("wait_v_resp", 16'(resp), 16'h005A);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    wait_rdy("horz_rdy");
    chk("horz_cmd", cmd, e.h);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("wait_h_resp", 16'(resp), 16'(exp_resp_h));
    send_resp = 1'b1; tick(); send_resp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mv: 8'h01, v: 16'h2002, h: 16'h3BF1};
    vecs[1] = '{mv: 8'h02, v: 16'h2002, h: 16'h33F1};
    vecs[2] = '{mv: 8'h04, v: 16'h2001, h: 16'h33F2};
    vecs[3] = '{mv: 8'h08, v: 16'h27F1, h: 16'h33F2};
    vecs[4] = '{mv: 8'h10, v: 16'h27F2, h: 16'h33F1};
    vecs[5] = '{mv: 8'h20, v: 16'h27F2, h: 16'h3BF1};
    vecs[6] = '{mv: 8'h40, v: 16'h27F1, h: 16'h3BF2};
    vecs[7] = '{mv: 8'h80, v: 16'h2001, h: 16'h3BF2};
    for (int i = 0; i < 32; i++) tour_mem[i] = vecs[i % 8].mv;

    rst_n = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_UART = 16'hABCD; cmd_rdy_UART = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_cmd", cmd, 16'hABCD);
    chk("idle_cmd_rdy", 16'(cmd_rdy), 16'd1);
    chk("idle_resp", 16'(resp), 16'h00A5);
    chk("idle_mv_indx", 16'(mv_indx), 16'd0);
    chk("idle_busy", 16'(tour_busy), 16'd0);
    chk("idle_done", 16'(tour_done), 16'd0);
    chk("idle_err", 16'(tour_err), 16'd0);

    // Full tour cycling every move
    cmd_rdy_UART = 1'b0;
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("tour_busy", 16'(tour_busy), 16'd1);
    for (int i = 0; i < 24; i++) run_move(i, (i == 23) ? 8'hA5 : 8'h5A);
    chk("end_done", 16'(tour_done), 16'd1);
    chk("end_busy", 16'(tour_busy), 16'd0);
    chk("end_mv_indx", 16'(mv_indx), 16'd23);
    chk("end_err", 16'(tour_err), 16'd0);
    tick();
    chk("done_drop", 16'(tour_done), 16'd0);
    chk("done_cnt", 16'(done_cnt), 16'd1);
    chk("leg_cnt", 16'(leg_cnt), 16'd48);

    // Abort in WAIT_V of move 5
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    for (int i = 0; i < 5; i++) run_move(i, 8'h5A);
    chk("ab_mv_indx", 16'(mv_indx), 16'd5);
    wait_rdy("ab_vert_rdy");
    chk("ab_vert_cmd", cmd, vecs[5].v);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
    #1;
    chk("ab_not_fwd", 16'(cmd_rdy), 16'd0);
    tick();
    chk("ab_resp", 16'(resp), 16'h00A5);
    chk("ab_err", 16'(tour_err), 16'd1);
    chk("ab_busy", 16'(tour_busy), 16'd1);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("ab_idle", 16'(tour_busy), 16'd0);
    chk("ab_fwd_cmd", cmd, 16'hF000);
    chk("ab_fwd_rdy", 16'(cmd_rdy), 16'd1);
    chk("ab_keep_idx", 16'(mv_indx), 16'd5);
    chk("ab_no_done", 16'(done_cnt), 16'd1);
    cmd_rdy_UART = 1'b0; cmd_UART = 16'h1234;

    // Illegal move at index 2
    tour_mem[2] = 8'h03;
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("il_err_clr", 16'(tour_err), 16'd0);
    run_move(0, 8'h5A);
    run_move(1, 8'h5A);
    chk("il_mv_indx", 16'(mv_indx), 16'd2);
    chk("il_no_rdy", 16'(cmd_rdy), 16'd0);
    tick();
    chk("il_idle", 16'(tour_busy), 16'd0);
    chk("il_err", 16'(tour_err), 16'd1);
    chk("il_rdy_idle", 16'(cmd_rdy), 16'd0);
    tour_mem[2] = vecs[2].mv;

    // Reset while in HORZ
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    run_move(0, 8'h5A);
    wait_rdy("rs_vert_rdy");
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("rs_horz_rdy", 16'(cmd_rdy), 16'd1);
    chk("rs_horz_cmd", cmd, vecs[1].h);
    chk("rs_horz_idx", 16'(mv_indx), 16'd1);
    rst_n = 1'b0; tick();
    chk("rs_idle", 16'(tour_busy), 16'd0);
    chk("rs_mv_indx", 16'(mv_indx), 16'd0);
    chk("rs_resp", 16'(resp), 16'h00A5);
    rst_n = 1'b1; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
